// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: access-size and FSM
// encodings, default bus timeout, and small byte-lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11   // behaves as a word access
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Halfwords need an even address, words (and the reserved size) a
  // multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte-lane enables for an aligned access.
  function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the enables pick the right one.
  function automatic logic [31:0] lane_wdata(input size_e size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ready, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword lane out of
// the bus word and zero- or sign-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    data   = rdata;
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_s[7]}}, byte_s};
      SZ_HALF: data = {{16{sign_ext & half_s[15]}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns a load/store from EX/MEM into a
// held bus request, stalls the pipeline until the bus completes, and returns
// an aligned/extended load result. Optional bus timeout: MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      CLR,
  input  logic                      op_valid,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [1:0]                Size,
  input  logic                      SignExt,
  input  logic [31:0]               Addr,
  input  logic [31:0]               WData,
  mem_access_unit_if.master         dmem,
  output logic                      stall,
  output logic [31:0]               RD,
  output logic                      addr_err,
  output logic                      bus_err
);

  state_e      state_r, state_s;
  logic [31:0] addr_r;
  size_e       size_r;
  logic        sext_r;
  logic        we_r;
  logic [31:0] wdata_r;
  logic [31:0] rd_r;
  logic [31:0] load_data_s;
  logic        mem_op_s;
  logic        misalign_s;
  logic        start_s;
  logic        capture_s;
  logic        tmo_hit_s;

  assign mem_op_s   = op_valid & (MemRead | MemWrite);
  assign misalign_s = is_misaligned(size_e'(Size), Addr[1:0]);
  assign start_s    = (state_r == ST_IDLE) & mem_op_s & ~misalign_s;
  // Only loads write RD; a store (including read+write) leaves it alone.
  assign capture_s  = (state_r == ST_BUSY) & dmem.ready & ~we_r;

  // Misaligned ops are flagged immediately and never reach the bus.
  assign addr_err = (state_r == ST_IDLE) & mem_op_s & misalign_s;
  assign stall    = start_s | (state_r == ST_BUSY);
  assign RD       = rd_r;

  assign dmem.req   = (state_r == ST_BUSY);
  assign dmem.we    = we_r;
  assign dmem.addr  = {addr_r[31:2], 2'b00};
  assign dmem.be    = byte_enables(size_r, addr_r[1:0]);
  assign dmem.wdata = lane_wdata(size_r, wdata_r);

  load_align u_load_align (
    .rdata    (dmem.rdata),
    .lane     (addr_r[1:0]),
    .size     (size_r),
    .sign_ext (sext_r),
    .data     (load_data_s)
  );

  // Next-state logic; DONE lasts one cycle so the pipeline advances once.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dmem.ready || tmo_hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, request latches and load-result register.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_r <= ST_IDLE;
      addr_r  <= 32'd0;
      size_r  <= SZ_BYTE;
      sext_r  <= 1'b0;
      we_r    <= 1'b0;
      wdata_r <= 32'd0;
      rd_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        addr_r  <= Addr;
        size_r  <= size_e'(Size);
        sext_r  <= SignExt;
        we_r    <= MemWrite;
        wdata_r <= WData;
      end
      if (capture_s) begin
        rd_r <= load_data_s;
      end else if (tmo_hit_s) begin
        rd_r <= 32'd0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tmo_cnt_r;
  logic        bus_err_r;

  // Last permitted BUSY cycle passed without the bus answering.
  assign tmo_hit_s = (state_r == ST_BUSY) & ~dmem.ready & (tmo_cnt_r == TMO_LAST);
  assign bus_err   = bus_err_r;

  // Per-transfer wait counter and the DONE-cycle error flag.
  always_ff @(posedge clk) begin
    if (CLR) begin
      tmo_cnt_r <= 32'd0;
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= tmo_hit_s;
      if (start_s) begin
        tmo_cnt_r <= 32'd0;
      end else if (state_r == ST_BUSY) begin
        tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver issues ops and
// queues the bus transfer the reference model predicts; a negedge monitor
// checks bus cycles, RD, stall and error outputs against that model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        CLR, op_valid, MemRead, MemWrite, SignExt;
  logic [1:0]  Size;
  logic [31:0] Addr, WData;
  logic        stall, addr_err, bus_err;
  logic [31:0] RD;

  always #5 clk = ~clk;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .CLR(CLR), .op_valid(op_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .Size(Size), .SignExt(SignExt), .Addr(Addr),
    .WData(WData), .dmem(dmem), .stall(stall), .RD(RD),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  lane;
  } txn_t;

  txn_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;
  logic        exp_addr_err = 1'b0;
  logic [31:0] rd_model = 32'd0;
  logic        expect_done = 1'b0;
  int          busy_run = 0;

  // responder controls
  int          force_waits = -1;
  logic        force_rd_en = 1'b0;
  logic [31:0] force_rd = 32'd0;
  int          busy_cnt = 0;
  int          target = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [1:0] lane, input logic [31:0] r);
    logic [31:0] v;
    int bits;
    if (sz == 2'd0) begin
      v = (r >> (8 * int'(lane))) & 32'hFF;
      bits = 8;
    end else if (sz == 2'd1) begin
      v = (r >> (16 * (int'(lane) / 2))) & 32'hFFFF;
      bits = 16;
    end else begin
      return r;
    end
    if (sx && v[bits-1]) v = v | ~((32'd1 << bits) - 32'd1);
    return v;
  endfunction

  // ---------------- bus responder ----------------
  always @(posedge clk) begin
    #2;
    if (dmem.req === 1'b1) begin
      if (busy_cnt == 0) target = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
      dmem.ready = (busy_cnt == target);
      dmem.rdata = force_rd_en ? force_rd : $urandom;
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      dmem.ready = ($urandom_range(0, 3) == 0);   // stray ready outside BUSY
      dmem.rdata = $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic hs;
  logic exp_be;
  txn_t t;
  always @(negedge clk) begin
    if (mon_en) begin
      hs = (dmem.req === 1'b1) && (dmem.ready === 1'b1) && !CLR;
      exp_be = 1'b0;
      check("addr_err", addr_err, exp_addr_err);
      if (expect_done) begin
        check("stall_in_done", stall, 32'd0);
        check("req_in_done", dmem.req, 32'd0);
        expect_done = 1'b0;
      end
`ifdef MEM_TIMEOUT_EN
      if (dmem.req === 1'b0 && busy_run == 4) begin
        exp_be = 1'b1;
        rd_model = 32'd0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("stall_after_timeout", stall, 32'd0);
      end
`endif
      check("bus_err", bus_err, exp_be);
      check("RD", RD, rd_model);
      if (dmem.req === 1'b1 && !CLR) check("stall_busy", stall, 32'd1);
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", dmem.req, 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("we", dmem.we, t.we);
          check("addr", dmem.addr, t.addr);
          check("be", dmem.be, t.be);
          if (t.we) check("wdata", dmem.wdata, t.wdata);
          else rd_model = model_load(t.size, t.sext, t.lane, dmem.rdata);
          expect_done = 1'b1;
        end
      end
      if (CLR) begin
        rd_model = 32'd0;
        if (dmem.req === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
        expect_done = 1'b0;
      end
      if (dmem.req === 1'b1 && dmem.ready !== 1'b1 && !CLR) busy_run++;
      else busy_run = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    exp_addr_err = 1'b0;
  endtask

  // Present one op from a posedge+1 slot with the DUT idle; returns at the
  // posedge+1 after the op has retired, with stall-high cycle count.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input logic drop,
                       output int stall_cnt);
    txn_t e;
    logic active, mis;
    int n;
    op_valid = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; SignExt = sx; Addr = a; WData = d;
    active = rd | wr;
    mis = active && model_misaligned(sz, a);
    exp_addr_err = mis;
    stall_cnt = 0;
    if (active && !mis) begin
      e.we = wr; e.addr = a & ~32'd3; e.be = model_be(sz, a); e.wdata = model_wdata(sz, d);
      e.size = sz; e.sext = sx; e.lane = 2'(a % 4);
      exp_q.push_back(e);
      @(negedge clk);
      check("stall_idle", stall, 32'd1);
      check("req_idle", dmem.req, 32'd0);
      stall_cnt = 1;
      if (drop) begin
        @(posedge clk); #1;
        op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (stall === 1'b1) stall_cnt++;
      end while (stall !== 1'b0 && n < 60);
      check("op_release", stall, 32'd0);
    end else begin
      @(negedge clk);
      check("stall_no_op", stall, 32'd0);
    end
    tick();
    idle_inputs();
    if (mis) check("req_after_misalign", dmem.req, 32'd0);
  endtask

  int sc;
  int r;
  logic rd_b, wr_b;

  initial begin
    CLR = 1'b1; idle_inputs(); Size = 2'd0; SignExt = 1'b0; Addr = 32'd0; WData = 32'd0;
    dmem.ready = 1'b0; dmem.rdata = 32'd0;
    tick(); tick();
    check("rst_stall", stall, 32'd0);
    check("rst_req", dmem.req, 32'd0);
    check("rst_RD", RD, 32'd0);
    check("rst_addr_err", addr_err, 32'd0);
    check("rst_bus_err", bus_err, 32'd0);
    CLR = 1'b0;
    mon_en = 1'b1;

    // LW 0x100: ready on the third BUSY cycle -> four stall cycles in total
    force_waits = 2; force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b0, sc);
    check("lw_rd", RD, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(sc), 32'd4);

    // LB / LBU at 0x103 with a 0x80 top byte; zero waits -> two stall cycles
    force_waits = 0; force_rd = 32'h80FF_FFFF;
    do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 1'b0, sc);
    check("lb_rd", RD, 32'hFFFF_FF80);
    check("min_stall_cycles", 32'(sc), 32'd2);
    do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 1'b0, sc);
    check("lbu_rd", RD, 32'h0000_0080);

    // SH at 0x202: RD untouched
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 1'b0, sc);
    check("sh_rd_kept", RD, 32'h0000_0080);

    // misaligned LW
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 1'b0, sc);
    check("misalign_stall_cycles", 32'(sc), 32'd0);

    // CLR in the second BUSY cycle, coincident with ready
    force_waits = 1; force_rd = 32'h1111_2222;
    op_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Addr = 32'h0000_0300;
    begin
      txn_t e;
      e.we = 1'b0; e.addr = 32'h0000_0300; e.be = 4'b1111; e.wdata = 32'h0;
      e.size = 2'd2; e.sext = 1'b0; e.lane = 2'd0;
      exp_q.push_back(e);
    end
    tick(); tick();
    CLR = 1'b1; idle_inputs();
    tick();
    CLR = 1'b0;
    check("clr_stall", stall, 32'd0);
    check("clr_req", dmem.req, 32'd0);
    check("clr_RD", RD, 32'd0);

    // randomized traffic
    force_waits = -1; force_rd_en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      rd_b = (r <= 3) || (r == 8);
      wr_b = (r >= 4 && r <= 8);
      do_op(rd_b, wr_b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, ($urandom_range(0, 3) == 0), sc);
      if ($urandom_range(0, 2) == 0) tick();
    end

`ifdef MEM_TIMEOUT_EN
    // bus never answers: four BUSY cycles then a bus_err DONE cycle
    force_waits = 1000;
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 1'b0, sc);
    check("timeout_RD", RD, 32'd0);
    check("timeout_stall_cycles", 32'(sc), 32'd5);
    force_waits = -1;
`endif

    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
